frame_buffer_arbiter: RTL and testbench

// - Shares the single-port 24-bit pixel BRAM between two requesters.
// - The write requester is write_controller; it supplies assembled pixels from UART bytes.
// - The read requester is the display/processing read path.
// - One BRAM access per cycle, round-robin on contention. Also tracks written-pixel count and flags frame completion.
// - Sits between write_controller, the pixel read path and the BRAM primitive.

---
 rtl/frame_buffer_arbiter_if.sv | 32 +++
 rtl/frame_buffer_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_arbiter_if.sv
// rtl/frame_buffer_arbiter_if.sv - write/read requester and BRAM port bundle for frame_buffer_arbiter
interface frame_buffer_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_err;
  logic              frame_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, dout,
    input  wr_ack, wr_err, frame_done, rd_ack, rd_valid, rd_data, en, we, addr, din
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, dout,
    output wr_ack, wr_err, frame_done, rd_ack, rd_valid, rd_data, en, we, addr, din
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// rtl/frame_buffer_arbiter.sv - round-robin write/read arbiter for the single-port pixel BRAM
// Optional ARB_STATS_EN adds saturating per-requester stall counters.
module frame_buffer_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 24,
  parameter int NUM_PIXELS = 66564,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ARB_STATS_EN
  output logic [15:0] wr_stall_cnt,
  output logic [15:0] rd_stall_cnt,
`endif
  frame_buffer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE_WR, ISSUE_RD} state_t;

  localparam logic [ADDR_W:0]   NUM_PIX  = (ADDR_W+1)'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  state_t            state, next_state;
  logic              last_rd;
  logic              wr_elig, rd_elig;
  logic              wr_oob, rd_oob;

  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;
  logic              frame_done_q, frame_done_d;
  logic              rd_ack_q, rd_ack_d;
  logic              rd_oob_q, rd_oob_d;
  logic [ADDR_W-1:0] wr_cnt, wr_cnt_d;

  logic [RD_LATENCY-1:0] pipe_v;
  logic [RD_LATENCY-1:0] pipe_oob;
  logic                  rd_valid_q;
  logic [DATA_W-1:0]     rd_data_q;

  // A requester is not eligible on the edge that ends its own ack cycle.
  assign wr_elig = bus.wr_req && (state != ISSUE_WR);
  assign rd_elig = bus.rd_req && (state != ISSUE_RD);
  assign wr_oob  = {1'b0, bus.wr_addr} >= NUM_PIX;
  assign rd_oob  = {1'b0, bus.rd_addr} >= NUM_PIX;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_rd <= 1'b1;
    end else begin
      state <= next_state;
      if (next_state == ISSUE_WR) last_rd <= 1'b0;
      else if (next_state == ISSUE_RD) last_rd <= 1'b1;
    end
  end

  always_comb begin
    next_state = IDLE;
    if (wr_elig && rd_elig) next_state = last_rd ? ISSUE_WR : ISSUE_RD;
    else if (wr_elig)       next_state = ISSUE_WR;
    else if (rd_elig)       next_state = ISSUE_RD;
  end

  // Values the BRAM port and acks take during the state being entered.
  always_comb begin
    en_d         = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    din_d        = din_q;
    wr_ack_d     = 1'b0;
    wr_err_d     = 1'b0;
    frame_done_d = 1'b0;
    rd_ack_d     = 1'b0;
    rd_oob_d     = 1'b0;
    wr_cnt_d     = wr_cnt;
    case (next_state)
      ISSUE_WR: begin
        wr_ack_d = 1'b1;
        if (wr_oob) begin
          wr_err_d = 1'b1;
        end else begin
          en_d   = 1'b1;
          we_d   = 1'b1;
          addr_d = bus.wr_addr;
          din_d  = bus.wr_data;
          if (wr_cnt == LAST_PIX) begin
            wr_cnt_d     = '0;
            frame_done_d = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt + 1'b1;
          end
        end
      end
      ISSUE_RD: begin
        rd_ack_d = 1'b1;
        rd_oob_d = rd_oob;
        if (!rd_oob) begin
          en_d   = 1'b1;
          addr_d = bus.rd_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      wr_ack_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      frame_done_q <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_oob_q     <= 1'b0;
      wr_cnt       <= '0;
    end else begin
      en_q         <= en_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      wr_ack_q     <= wr_ack_d;
      wr_err_q     <= wr_err_d;
      frame_done_q <= frame_done_d;
      rd_ack_q     <= rd_ack_d;
      rd_oob_q     <= rd_oob_d;
      wr_cnt       <= wr_cnt_d;
    end
  end

  // pipe_v[RD_LATENCY-1] is set during the cycle dout carries the issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v     <= '0;
      pipe_oob   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      pipe_v[0]   <= rd_ack_q;
      pipe_oob[0] <= rd_oob_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_oob[i] <= pipe_oob[i-1];
      end
      rd_valid_q <= pipe_v[RD_LATENCY-1];
      if (pipe_v[RD_LATENCY-1]) rd_data_q <= pipe_oob[RD_LATENCY-1] ? '0 : bus.dout;
    end
  end

  assign bus.en         = en_q;
  assign bus.we         = we_q;
  assign bus.addr       = addr_q;
  assign bus.din        = din_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.frame_done = frame_done_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;

`ifdef ARB_STATS_EN
  logic [15:0] wr_stall_q, rd_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_stall_q <= '0;
      rd_stall_q <= '0;
    end else begin
      if (wr_elig && next_state != ISSUE_WR && wr_stall_q != 16'hFFFF)
        wr_stall_q <= wr_stall_q + 16'd1;
      if (rd_elig && next_state != ISSUE_RD && rd_stall_q != 16'hFFFF)
        rd_stall_q <= rd_stall_q + 16'd1;
    end
  end

  assign wr_stall_cnt = wr_stall_q;
  assign rd_stall_cnt = rd_stall_q;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb/tb_frame_buffer_arbiter.sv - self-checking bench for frame_buffer_arbiter
module tb_frame_buffer_arbiter;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 24;
  localparam int NP     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;

  logic [DATA_W-1:0] exp_rd_q[$];
  logic [DATA_W-1:0] ref_mem [0:15];
  logic [DATA_W-1:0] bram    [0:255];

  frame_buffer_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

`ifdef ARB_STATS_EN
  logic [15:0] wr_stall_cnt, rd_stall_cnt;
`endif

  frame_buffer_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PIXELS(NP), .RD_LATENCY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef ARB_STATS_EN
    .wr_stall_cnt(wr_stall_cnt),
    .rd_stall_cnt(rd_stall_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.en) begin
      if (bus.we) bram[bus.addr[7:0]] <= bus.din;
      else        bus.dout <= bram[bus.addr[7:0]];
    end
  end

  // Scoreboard: frame counter model and expected read data queue.
  always @(negedge clk) begin
    logic exp_fd;
    logic [DATA_W-1:0] exp_d;
    if (rst) begin
      fd_cnt = 0;
    end else begin
      if (bus.wr_ack && !bus.wr_err) begin
        exp_fd = (fd_cnt == NP - 1);
        fd_cnt = exp_fd ? 0 : fd_cnt + 1;
        checks++;
        if (bus.frame_done !== exp_fd) begin
          errors++;
          $display("FAIL sb_frame_done got %0b want %0b", bus.frame_done, exp_fd);
        end
      end else if (bus.frame_done) begin
        checks++;
        errors++;
        $display("FAIL sb_frame_done_spurious got 1 want 0");
      end
      if (bus.rd_valid) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL sb_rd_valid_unexpected got rd_valid=1 want 0");
        end else begin
          exp_d = exp_rd_q.pop_front();
          if (bus.rd_data !== exp_d) begin
            errors++;
            $display("FAIL sb_rd_data got %h want %h", bus.rd_data, exp_d);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             output logic ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    for (int i = 0; i < 4 && !ok; i++) begin
      step();
      lat++;
      if (bus.wr_ack) ok = 1'b1;
    end
    bus.wr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.en, bus.we, bus.wr_ack, bus.wr_err, bus.frame_done, bus.rd_ack, bus.rd_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {bus.en, bus.we, bus.wr_ack, bus.wr_err, bus.frame_done, bus.rd_ack, bus.rd_valid});
    end
    checks++;
    if ({bus.addr, bus.din, bus.rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h din=%h rd_data=%h want 0", bus.addr, bus.din, bus.rd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    logic ok;
    int   lat;
    issue_write(18'd5, 24'hA1B2C3, ok, lat);
    ref_mem[5] = 24'hA1B2C3;
    checks++;
    if (!ok || lat != 1) begin
      errors++;
      $display("FAIL wr_latency got ok=%0b lat=%0d want ok=1 lat=1", ok, lat);
    end
    checks++;
    if ({bus.en, bus.we, bus.wr_err} !== 3'b110) begin
      errors++;
      $display("FAIL wr_issue_ctrl got en,we,err=%b want 110", {bus.en, bus.we, bus.wr_err});
    end
    checks++;
    if (bus.addr !== 18'd5 || bus.din !== 24'hA1B2C3) begin
      errors++;
      $display("FAIL wr_issue_bus got addr=%0d din=%h want 5 a1b2c3", bus.addr, bus.din);
    end
    step();
    checks++;
    if (bus.en !== 1'b0 || bus.wr_ack !== 1'b0 || bus.addr !== 18'd5) begin
      errors++;
      $display("FAIL wr_idle got en=%0b ack=%0b addr=%0d want 0 0 5", bus.en, bus.wr_ack, bus.addr);
    end
  endtask

  task automatic test_read();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 18'd5;
    step();
    checks++;
    if ({bus.rd_ack, bus.en, bus.we} !== 3'b110 || bus.addr !== 18'd5) begin
      errors++;
      $display("FAIL rd_issue got ack,en,we=%b addr=%0d want 110 5", {bus.rd_ack, bus.en, bus.we}, bus.addr);
    end
    if (bus.rd_ack) exp_rd_q.push_back(ref_mem[5]);
    bus.rd_req = 1'b0;
    step();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_early got 1 want 0");
    end
    step();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 24'hA1B2C3) begin
      errors++;
      $display("FAIL rd_valid_timing got valid=%0b data=%h want 1 a1b2c3", bus.rd_valid, bus.rd_data);
    end
    step();
  endtask

  task automatic test_contention();
    logic exp_wr;
    rst = 1'b1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 18'd2;
    bus.wr_data = 24'h0F0F0F;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 18'd5;
    step();
    rst = 1'b0;
    ref_mem[2] = 24'h0F0F0F;
    for (int c = 1; c <= 8; c++) begin
      step();
      exp_wr = (c % 2) == 1;
      checks++;
      if (bus.wr_ack !== exp_wr || bus.rd_ack !== !exp_wr || bus.en !== 1'b1) begin
        errors++;
        $display("FAIL contention_c%0d got wr_ack=%0b rd_ack=%0b en=%0b want %0b %0b 1",
                 c, bus.wr_ack, bus.rd_ack, bus.en, exp_wr, !exp_wr);
      end
      if (bus.rd_ack) exp_rd_q.push_back(ref_mem[5]);
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
`ifdef ARB_STATS_EN
    checks++;
    if (rd_stall_cnt !== 16'd1 || wr_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stall_cnt got wr=%0d rd=%0d want 0 1", wr_stall_cnt, rd_stall_cnt);
    end
`endif
    repeat (3) step();
  endtask

  task automatic test_frame_and_oob_write();
    logic ok;
    int   lat;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < NP; k++) begin
      if (k == 3) begin
        issue_write(ADDR_W'(NP), 24'hDEAD01, ok, lat);
        checks++;
        if (!ok || {bus.wr_err, bus.en, bus.we, bus.frame_done} !== 4'b1000) begin
          errors++;
          $display("FAIL oob_write got ok=%0b err,en,we,fd=%b want 1 1000",
                   ok, {bus.wr_err, bus.en, bus.we, bus.frame_done});
        end
      end
      issue_write(ADDR_W'(k), DATA_W'(24'h100000 + k), ok, lat);
      ref_mem[k] = DATA_W'(24'h100000 + k);
      checks++;
      if (!ok || bus.wr_err !== 1'b0 || bus.frame_done !== (k == NP - 1)) begin
        errors++;
        $display("FAIL frame_w%0d got ok=%0b err=%0b fd=%0b want 1 0 %0b",
                 k, ok, bus.wr_err, bus.frame_done, (k == NP - 1));
      end
    end
    issue_write(18'd0, 24'h200000, ok, lat);
    ref_mem[0] = 24'h200000;
    checks++;
    if (!ok || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_wrap got ok=%0b fd=%0b want 1 0", ok, bus.frame_done);
    end
    step();
  endtask

  task automatic test_oob_read();
    bus.rd_req  = 1'b1;
    bus.rd_addr = ADDR_W'(NP);
    step();
    checks++;
    if (bus.rd_ack !== 1'b1 || bus.en !== 1'b0) begin
      errors++;
      $display("FAIL oob_rd_issue got ack=%0b en=%0b want 1 0", bus.rd_ack, bus.en);
    end
    if (bus.rd_ack) exp_rd_q.push_back('0);
    bus.rd_req = 1'b0;
    step();
    step();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL oob_rd_data got valid=%0b data=%h want 1 000000", bus.rd_valid, bus.rd_data);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 18'd5;
    step();
    checks++;
    if (bus.rd_ack !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_rd_ack got 0 want 1");
    end
    bus.rd_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({bus.en, bus.we, bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.frame_done} !== 6'b0 ||
        {bus.addr, bus.din, bus.rd_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid_rd_outputs got ctrl=%b addr=%h din=%h rd_data=%h want 0",
               {bus.en, bus.we, bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.frame_done},
               bus.addr, bus.din, bus.rd_data);
    end
    rst = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 18'd1;
    bus.wr_data = 24'h333333;
    bus.rd_req  = 1'b1;
    step();
    ref_mem[1] = 24'h333333;
    checks++;
    if (bus.wr_ack !== 1'b1 || bus.rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_grant got wr_ack=%0b rd_ack=%0b want 1 0", bus.wr_ack, bus.rd_ack);
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    step();
    checks++;
    if (bus.rd_ack !== 1'b0 || bus.en !== 1'b0) begin
      errors++;
      $display("FAIL withdrawn_rd got rd_ack=%0b en=%0b want 0 0", bus.rd_ack, bus.en);
    end
    repeat (4) step();
  endtask

  initial begin
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    for (int i = 0; i < 256; i++) bram[i] = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_frame_and_oob_write();
    test_oob_read();
    test_reset_mid_read();

    checks++;
    if (exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_queue_drain got %0d pending want 0", exp_rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
